// File: rtl/mul_div_unit.sv
// RV32M execute unit: single-cycle-issue multiply (2-cycle latency) and
// iterative restoring divide with a one-cycle done pulse and stall request.
module mul_div_unit #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mulDiv_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);
    localparam int STEPS = XLEN / DIV_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t          state;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rem;
    logic [4:0]      rd;
    logic [CNT_W-1:0] cnt;
    logic            neg_q;
    logic            neg_r;

    logic            idle_or_done;
    logic            accept;
    logic            in_signed;
    logic            in_neg_a;
    logic            in_neg_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] special_res;

    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    logic [XLEN:0]   r_next;
    logic [XLEN-1:0] q_next;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign accept       = start && !kill && idle_or_done;
    assign busy         = !idle_or_done;
    assign stall_req    = !rst && (busy || accept);
    assign we_out       = done && (rd_out != 5'd0);

    assign in_signed   = !mulDiv_op[0];
    assign in_neg_a    = in_signed && op_a[XLEN-1];
    assign in_neg_b    = in_signed && op_b[XLEN-1];
    assign abs_a       = in_neg_a ? -op_a : op_a;
    assign abs_b       = in_neg_b ? -op_b : op_b;
    assign div_zero    = (op_b == '0);
    assign div_ovf     = in_signed && (op_a == INT_MIN) && (op_b == '1);
    assign special_res = div_zero ? (mulDiv_op[1] ? op_a : '1)
                                  : (mulDiv_op[1] ? '0 : INT_MIN);

    // Extending to 2*XLEN keeps the low half of the 33x33 signed product exact
    assign mul_a   = {{XLEN{a[XLEN-1] && !(op[1] && op[0])}}, a};
    assign mul_b   = {{XLEN{b[XLEN-1] && !op[1]}}, b};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // a doubles as the dividend/quotient shift register during DIV
    always_comb begin
        r_next = {1'b0, rem};
        q_next = a;
        for (int i = 0; i < DIV_BITS; i++) begin
            r_next = {r_next[XLEN-1:0], q_next[XLEN-1]};
            q_next = {q_next[XLEN-2:0], 1'b0};
            if (r_next >= {1'b0, b}) begin
                r_next    = r_next - {1'b0, b};
                q_next[0] = 1'b1;
            end
        end
    end

    assign q_fix = neg_q ? -a : a;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            rem    <= '0;
            rd     <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else if (kill) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        op <= mulDiv_op[1:0];
                        rd <= rd_in;
                        a  <= mulDiv_op[2] ? abs_a : op_a;
                        b  <= mulDiv_op[2] ? abs_b : op_b;
                        if (!mulDiv_op[2]) begin
                            state <= MUL;
                        end else if (div_zero || div_ovf) begin
                            result <= special_res;
                            rd_out <= rd_in;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            rem   <= '0;
                            cnt   <= CNT_LOAD;
                            neg_q <= in_neg_a ^ in_neg_b;
                            neg_r <= in_neg_a;
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    result <= mul_res;
                    rd_out <= rd;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DIV: begin
                    a   <= q_next;
                    rem <= r_next[XLEN-1:0];
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= op[1] ? r_fix : q_fix;
                    rd_out <= rd;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multi-cycle unit for the RV32M instructions.
- Consumes the operands, rd and mulDiv_op that the issue stage registers, plus a valid from execute decode.
- Returns a 32-bit result with a one-cycle done pulse.
- Raises a stall request toward the scoreboard while it is busy.

Parameters:
XLEN, 32, operand and result width.
DIV_BITS, 1, quotient bits resolved per divide cycle; legal values 1, 2, 4; XLEN must be a multiple of it.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
start  in  1  valid M-extension instruction presented this cycle
mulDiv_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value (dividend / multiplicand)
op_b  in  XLEN  rs2 value (divisor / multiplier)
rd_in  in  5  destination register
kill  in  1  flush (exception or taken branch); aborts any operation
busy  out  1  state != IDLE and state != DONE
stall_req  out  1  equals busy OR (start AND accepted); holds upstream
done  out  1  one-cycle result-valid pulse
result  out  XLEN  result, valid while done=1
rd_out  out  5  rd of the completing operation
we_out  out  1  done AND (rd_out != 0)

Behaviour:
Reset (async, any state):
- State goes to IDLE.
- busy, stall_req, done, we_out, result, rd_out all go to 0.
- Internal counters clear.

States: IDLE, MUL, DIV, FIX, DONE.

Accept:
- start is sampled in IDLE or DONE only. In DONE this allows back-to-back issue.
- start is ignored in MUL, DIV and FIX. Upstream is held by stall_req.
- On accept, op_a, op_b, mulDiv_op and rd_in are latched. Inputs are not used afterward.

Cycle numbering: cycle 0 is the cycle in which start is accepted.

Multiply (op[2]=0):
- Cycle 1, state MUL: a 33x33 signed product is formed.
  - Operands are sign-extended for signed operands: rs1 for MUL/MULH/MULHSU; rs2 for MUL/MULH.
  - Otherwise operands are zero-extended.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- Product is registered; DONE in cycle 2, done=1.

Divide (op[2]=1):
- Special cases, resolved in cycle 0 and reaching DONE in cycle 1:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Normal path:
  - Cycle 0: absolute values are latched for the signed ops.
  - State DIV for XLEN/DIV_BITS cycles (cycles 1..32 at default) of restoring division. Remainder register is XLEN+1 bits.
  - Cycle 33, state FIX: sign correction.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
  - Cycle 34, state DONE.
- General latency: XLEN/DIV_BITS + 2.

DONE:
- Lasts exactly one cycle.
- Goes to IDLE, or to MUL/DIV/DONE if a new start is accepted.
- result and rd_out hold their values until the next done. done and we_out fall.

kill:
- Has priority over start and over completion.
- Next edge forces IDLE. busy, stall_req and done go to 0. No done is ever produced for a killed operation.
- kill in the same cycle as start: start is discarded.
- kill while in DONE: done is already visible that cycle. Issuing that write-back is the commit stage's job; this unit only returns to IDLE.

Arithmetic:
- All intermediate widths are explicit.
- The divide counter wraps only through reload on accept; it never free-runs.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd=5 -> cycle 2: done=1, result=0xFFFFFFEB, rd_out=5, we_out=1; cycle 3: done=0.
- MULH 0x80000000*0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> done at cycle 34, result 14, busy=1 cycles 1..33; REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
- DIV x/0 -> cycle 1, result 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIV started, kill at cycle 10 -> IDLE at cycle 11, no done through cycle 40; new MUL at cycle 12 completes at cycle 14. rst asserted mid-DIV -> all outputs 0 immediately.
- Back-to-back: new start accepted in DONE cycle -> second done two cycles later; rd=0 -> done=1, we_out=0. start asserted during DIV -> ignored, result unchanged.
